// File: rtl/heap_sift_initiator.sv
// One-step sift-down engine driving a level's translated upper memory port.
// Define HEAP_MAX_EN for max-heap ordering; min-heap ordering is used otherwise.
module heap_sift_initiator #(
  parameter int LEVEL = 3,
  parameter int WIDTH = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEVEL-3:0]   cmd_idx,
  input  logic [WIDTH:0]     cmd_val,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_swap,
  output logic               rsp_side,
  output logic [WIDTH:0]     rsp_child,
  output logic [LEVEL-2:0]   addr_U,
  output logic               wr_en_U,
  output logic [WIDTH:0]     data_U,
  input  logic [WIDTH:0]     q_U
);

  typedef enum logic [2:0] {IDLE, RD_L, RD_R, CMP, WR, RESP} state_t;

  state_t             state;
  logic [LEVEL-3:0]   idx;
  logic [WIDTH:0]     val;
  logic [WIDTH:0]     left_q;
  logic               pick_right;
  logic [WIDTH:0]     win;
  logic               do_swap;

  // In CMP, left_q holds the left child and q_U carries the right child.
  always_comb begin
    pick_right = 1'b0;
    win        = left_q;
    do_swap    = 1'b0;
`ifdef HEAP_MAX_EN
    pick_right = (q_U > left_q);
    win        = pick_right ? q_U : left_q;
    do_swap    = (win > val);
`else
    pick_right = (q_U < left_q);
    win        = pick_right ? q_U : left_q;
    do_swap    = (win < val);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      val       <= '0;
      left_q    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_swap  <= 1'b0;
      rsp_side  <= 1'b0;
      rsp_child <= '0;
      addr_U    <= '0;
      wr_en_U   <= 1'b0;
      data_U    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            idx       <= cmd_idx;
            val       <= cmd_val;
            addr_U    <= {1'b0, cmd_idx};
            cmd_ready <= 1'b0;
            state     <= RD_L;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD_L: begin
          addr_U <= {1'b1, idx};
          state  <= RD_R;
        end
        RD_R: begin
          left_q <= q_U;
          state  <= CMP;
        end
        CMP: begin
          rsp_side  <= pick_right;
          rsp_child <= win;
          rsp_swap  <= do_swap;
          if (do_swap) begin
            addr_U  <= {pick_right, idx};
            wr_en_U <= 1'b1;
            data_U  <= val;
            state   <= WR;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WR: begin
          wr_en_U   <= 1'b0;
          data_U    <= '0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_sift_initiator.sv
// Directed bench for heap_sift_initiator with a one-cycle-latency RAM behind the port.
// Define HEAP_MAX_EN to exercise the max-heap build.
module tb_heap_sift_initiator;
  localparam int LEVEL = 3;
  localparam int WIDTH = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEVEL-3:0]  cmd_idx;
  logic [WIDTH:0]    cmd_val;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_swap;
  logic              rsp_side;
  logic [WIDTH:0]    rsp_child;
  logic [LEVEL-2:0]  addr_U;
  logic              wr_en_U;
  logic [WIDTH:0]    data_U;
  logic [WIDTH:0]    q_U;

  logic [WIDTH:0]    mem [4];
  int                vec_cnt = 0;
  int                err_cnt = 0;

  always #5 clk = ~clk;

  heap_sift_initiator #(.LEVEL(LEVEL), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_swap(rsp_swap),
    .rsp_side(rsp_side), .rsp_child(rsp_child),
    .addr_U(addr_U), .wr_en_U(wr_en_U), .data_U(data_U), .q_U(q_U)
  );

  // Synchronous RAM; a write is dropped if reset is high on its edge.
  always @(posedge clk) begin
    q_U <= mem[addr_U];
    if (wr_en_U && !reset) mem[addr_U] <= data_U;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string name, input logic idx, input logic [WIDTH:0] val,
                         input logic exp_swap, input logic exp_side,
                         input logic [WIDTH:0] exp_child, input int hold);
    int n;
    int lat;
    int wr_seen;
    int wr_lat;
    logic [LEVEL-2:0] wa;
    logic [WIDTH:0]   wd;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check({name, "/ready"}, cmd_ready, 1);
    cmd_idx = idx; cmd_val = val; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check({name, "/busy"}, cmd_ready, 0);
    lat = 0; wr_seen = 0; wr_lat = 0; wa = '0; wd = '0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
      if (wr_en_U) begin
        wr_seen++; wa = addr_U; wd = data_U; wr_lat = lat;
      end else begin
        check({name, "/data_idle"}, data_U, 0);
      end
    end
    check({name, "/latency"}, lat, exp_swap ? 4 : 3);
    check({name, "/writes"}, wr_seen, exp_swap ? 1 : 0);
    if (exp_swap) begin
      check({name, "/wr_addr"}, wa, {exp_side, idx});
      check({name, "/wr_data"}, wd, val);
      check({name, "/wr_cycle"}, wr_lat, 3);
    end
    check({name, "/swap"}, rsp_swap, exp_swap);
    check({name, "/side"}, rsp_side, exp_side);
    check({name, "/child"}, rsp_child, exp_child);
    // Stray commands while busy must be ignored.
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_idx = ~idx; cmd_val = '0;
      tick();
      check({name, "/hold_valid"}, rsp_valid, 1);
      check({name, "/hold_child"}, rsp_child, exp_child);
      check({name, "/hold_swap"}, rsp_swap, exp_swap);
      check({name, "/hold_side"}, rsp_side, exp_side);
      check({name, "/hold_ready"}, cmd_ready, 0);
      check({name, "/hold_wr"}, wr_en_U, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, "/rsp_drop"}, rsp_valid, 0);
    check({name, "/ready_back"}, cmd_ready, 1);
    tick();
    check({name, "/still_idle"}, cmd_ready, 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "/cmd_ready"}, cmd_ready, 0);
    check({name, "/rsp_valid"}, rsp_valid, 0);
    check({name, "/rsp_swap"}, rsp_swap, 0);
    check({name, "/rsp_side"}, rsp_side, 0);
    check({name, "/rsp_child"}, rsp_child, 0);
    check({name, "/addr"}, addr_U, 0);
    check({name, "/wr_en"}, wr_en_U, 0);
    check({name, "/data"}, data_U, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_idx = '0; cmd_val = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '1;
    tick(); tick();
    check_reset_vals("por");
    reset = 1'b0;
    check("por/ready_low", cmd_ready, 0);
    tick();
    check("por/ready_rise", cmd_ready, 1);

`ifdef HEAP_MAX_EN
    mem[0] = 16'd5; mem[2] = 16'd9;
    run_vec("max_right", 1'b0, 16'd7, 1'b1, 1'b1, 16'd9, 2);
    check("max_right/mem_r", mem[2], 16'd7);
    check("max_right/mem_l", mem[0], 16'd5);
    mem[1] = 16'd0; mem[3] = 16'd0;
    run_vec("max_empty", 1'b1, 16'd8, 1'b0, 1'b0, 16'd0, 0);
    mem[1] = 16'd12; mem[3] = 16'd12;
    run_vec("max_tie", 1'b1, 16'd3, 1'b1, 1'b0, 16'd12, 0);
    check("max_tie/mem_l", mem[1], 16'd3);
    mem[0] = 16'd5; mem[2] = 16'd9;
`else
    mem[1] = 16'd5; mem[3] = 16'd9;
    run_vec("left_swap", 1'b1, 16'd7, 1'b1, 1'b0, 16'd5, 3);
    check("left_swap/mem_l", mem[1], 16'd7);
    check("left_swap/mem_r", mem[3], 16'd9);
    mem[0] = 16'd20; mem[2] = 16'd3;
    run_vec("right_swap", 1'b0, 16'd10, 1'b1, 1'b1, 16'd3, 0);
    check("right_swap/mem_r", mem[2], 16'd10);
    mem[0] = 16'd4; mem[2] = 16'd4;
    run_vec("tie_noswap", 1'b0, 16'd4, 1'b0, 1'b0, 16'd4, 1);
    mem[1] = 16'hFFFF; mem[3] = 16'hFFFF;
    run_vec("empty", 1'b1, 16'd8, 1'b0, 1'b0, 16'hFFFF, 0);
    check("empty/mem_l", mem[1], 16'hFFFF);
    mem[0] = 16'd5; mem[2] = 16'd9;
`endif

    // Reset while WR is on the port: both children hold 5/9, val 7 forces a swap.
    cmd_idx = 1'b0; cmd_val = 16'd7; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!wr_en_U && n < 10) begin tick(); n++; end
    check("rst_wr/reached_wr", wr_en_U, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_wr");
    check("rst_wr/mem_l", mem[0], 16'd5);
    check("rst_wr/mem_r", mem[2], 16'd9);
    reset = 1'b0;
    tick();
    check("rst_wr/ready_rise", cmd_ready, 1);
    check("rst_wr/no_rsp", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/heap_sift_initiator.md
# heap_sift_initiator

Single-step sift-down engine for the dual heap. It drives the translated upper memory port of one heap level, which splits into left and right child RAMs. For a given parent index it reads both children, selects the winning child, and writes the parent's value down into that child slot when a swap is required. It returns the displaced child value so the level above can store it. It is the initiator paired with the level's address-translation responder.

## Interface
Parameters:
- LEVEL, 3, heap level number; the upper address is LEVEL-1 bits, and the parent/child index is LEVEL-2 bits.
- WIDTH, 15, MSB index of a record; records are WIDTH+1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle and accepting a command.
- cmd_idx  in  LEVEL-2  parent index; both children sit at this index in the L and R memories.
- cmd_val  in  WIDTH+1  value being sifted down from the parent.
- rsp_valid  out  1  result available; held until accepted.
- rsp_ready  in  1  consumer accepts the result.
- rsp_swap  out  1  1 means cmd_val was written into a child slot.
- rsp_side  out  1  winning child: 0 = left, 1 = right.
- rsp_child  out  WIDTH+1  winning child's value as read before any write.
- addr_U  out  LEVEL-1  upper address; the MSB selects right (1) or left (0), and the low bits carry cmd_idx.
- wr_en_U  out  1  write strobe.
- data_U  out  WIDTH+1  write data.
- q_U  in  WIDTH+1  read data, valid one clock after addr_U is presented (synchronous RAM).

## Operation
- FSM states: IDLE, RD_L, RD_R, CMP, WR, RESP.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid is high, latch cmd_idx and cmd_val, then go to RD_L.
- RD_L:
  - addr_U={0,idx}, wr_en_U=0.
  - Go to RD_R.
- RD_R:
  - addr_U={1,idx}.
  - Capture q_U (left child) into left_q.
  - Go to CMP.
- CMP:
  - addr_U stays {1,idx}; q_U now carries the right child.
  - Select the winner: left if left_q <= q_U (unsigned), otherwise right. Ties go to left.
  - swap = (winner < val), strictly less.
  - Latch rsp_side, rsp_child and rsp_swap.
  - If swap=1, go to WR; otherwise go to RESP.
- WR:
  - addr_U={rsp_side,idx}, wr_en_U=1, data_U=val, for exactly one cycle.
  - Go to RESP.
- RESP:
  - rsp_valid=1, and all rsp_* fields stay stable.
  - When rsp_ready is high, go to IDLE.
- wr_en_U is 0 in every state except WR. data_U is 0 whenever wr_en_U=0.
- An empty slot holds all-ones. It is never smaller than any value, so it never wins a swap against a real value and needs no special case.
- cmd_ready is 0 in every state except IDLE, so there is only one command in flight.

## Timing
- All outputs are registered and take their next-state values on the clock edge.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_swap=0, rsp_side=0, rsp_child=0, addr_U=0, wr_en_U=0, data_U=0, state IDLE.
- cmd_ready rises on the first edge after reset deasserts.
- Command accepted at edge T0:
  - RD_L during T0..T1.
  - RD_R during T1..T2.
  - CMP during T2..T3.
  - With swap: WR during T3..T4, and rsp_valid rises at T4 (latency 4).
  - Without swap: rsp_valid rises at T3 (latency 3).
- rsp_valid and rsp_ready high together at an edge moves the FSM to IDLE. cmd_ready returns at that same edge, and the next command can be accepted one edge later.
- Reset asserted in any state, including WR, forces all reset values at the next edge. A write in the WR cycle completes only if reset was low at that edge. No partial response is emitted.
- cmd_valid seen outside IDLE is ignored and is not queued.

## Configuration
- HEAP_MAX_EN defined: max-heap ordering.
  - The winner is the larger child; ties go to left.
  - swap = (winner > val), strictly greater.
  - The empty sentinel becomes all-zeros.
- HEAP_MAX_EN undefined: min-heap ordering as described above.
- Ports, FSM and timing are identical in both builds.

## Test plan
All scenarios use LEVEL=3, WIDTH=15 and a one-cycle-latency RAM model behind the translator.
- Left wins, swap: L[1]=5, R[1]=9, cmd idx=1 val=7 -> one write at addr_U=2'b01, data 7, at T3. Response: swap=1, side=0, child=5. Afterwards L[1]=7.
- Right wins, swap: L[0]=20, R[0]=3, val=10 -> write at addr_U=2'b10, data 10. Response: side=1, child=3.
- Tie and no swap: L[0]=4, R[0]=4, val=4 -> no wr_en_U pulse. Response: swap=0, side=0, child=4, rsp_valid at T3.
- Empty children: L[1]=R[1]=16'hFFFF, val=8 -> swap=0, no write.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles -> rsp fields stay stable and cmd_ready stays 0.
  - Assert reset during WR -> all outputs at reset values next cycle, cmd_ready=1 one cycle after release.
- HEAP_MAX_EN build: L[0]=5, R[0]=9, val=7 -> write data 7 at addr_U=2'b10. Response: swap=1, side=1, child=9.
